// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Desc     : Shared definitions for the layer sequencer: descriptor field
//            layout, layer type encodings, FSM state encoding and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

  localparam int DESC_W   = 38;

  // Descriptor field layout (bit offsets / widths)
  localparam int LAST_BIT = 37;
  localparam int TYPE_LSB = 35;
  localparam int TYPE_W   = 2;
  localparam int ACT_BIT  = 34;
  localparam int WST_LSB  = 24;
  localparam int WST_W    = 10;
  localparam int CH_LSB   = 20;
  localparam int CH_W     = 4;
  localparam int FN_LSB   = 14;
  localparam int FN_W     = 6;
  localparam int WIN_LSB  = 0;
  localparam int WIN_W    = 14;

  typedef enum logic [1:0] {
    TYPE_POINT   = 2'b00,
    TYPE_DEPTH   = 2'b01,
    TYPE_SKIP    = 2'b10,
    TYPE_ILLEGAL = 2'b11
  } layer_type_t;

  typedef struct packed {
    logic              last;
    layer_type_t       ltype;
    logic              act_en;
    logic [WST_W-1:0]  w_start;
    logic [CH_W-1:0]   ch_max;
    logic [FN_W-1:0]   fn_max;
    logic [WIN_W-1:0]  win_max;
  } desc_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_FIRE  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_NEXT  = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  // Split a raw table word into named fields.
  function automatic desc_t unpack_desc(input logic [DESC_W-1:0] raw);
    desc_t d;
    d.last    = raw[LAST_BIT];
    d.ltype   = layer_type_t'(raw[TYPE_LSB +: TYPE_W]);
    d.act_en  = raw[ACT_BIT];
    d.w_start = raw[WST_LSB +: WST_W];
    d.ch_max  = raw[CH_LSB +: CH_W];
    d.fn_max  = raw[FN_LSB +: FN_W];
    d.win_max = raw[WIN_LSB +: WIN_W];
    return d;
  endfunction

  // A descriptor aborts the pass if its type is illegal, or if an engine
  // layer has any zero loop bound (the engines cannot run an empty loop).
  function automatic logic desc_is_bad(input desc_t d);
    logic engine_layer;
    engine_layer = (d.ltype == TYPE_POINT) || (d.ltype == TYPE_DEPTH);
    return (d.ltype == TYPE_ILLEGAL) ||
           (engine_layer && ((d.ch_max == '0) || (d.fn_max == '0) ||
                             (d.win_max == '0)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/layer_desc_regfile.sv
`default_nettype none
// ============================================================================
// Module   : layer_desc_regfile
// Desc     : NUM_LAYERS x DESC_W descriptor table, one synchronous write
//            port and one combinational read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module layer_desc_regfile #(
  parameter int NUM_LAYERS = 16,
  parameter int IDX_W      = 4,
  parameter int DESC_W     = 38
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DESC_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DESC_W-1:0] o_rdata
);
  import seq_pkg::*;

  logic [DESC_W-1:0] r_mem [NUM_LAYERS];

  // Table write; the host must fill every used slot before a pass.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer
// Desc     : Walks a programmable table of layer descriptors, presents each
//            layer's configuration to the pointwise/depthwise engines, fires
//            the matching one-cycle enable, waits for that engine's end
//            pulse and advances; pulses done at the end of the pass.
//            Optional macro SEQ_PERF_CNT_EN adds perf_cycles and
//            perf_layer_last cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
  parameter int NUM_LAYERS = 16,
  parameter int IDX_W      = 4,
  parameter int DESC_W     = 38
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [DESC_W-1:0] cfg_data,
  input  logic              start,
  input  logic              point_end,
  input  logic              dw_end,
  output logic              point_en,
  output logic              dw_en,
  output logic [9:0]        w_start_address,
  output logic [3:0]        filter_channel_max,
  output logic [5:0]        filter_number_max,
  output logic [13:0]       window_size_max,
  output logic              act_en,
  output logic [IDX_W-1:0]  layer_idx,
  output logic              busy,
  output logic              done,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_layer_last,
`endif
  output logic              err
);
  import seq_pkg::*;

  state_t            r_state;
  state_t            w_next;
  desc_t             r_desc;
  logic [IDX_W-1:0]  r_idx;
  logic              r_err;
  logic [DESC_W-1:0] w_rd_data;
  logic              w_accept;
  logic              w_bad;
  logic              w_end_match;
  logic              w_at_end;
  logic              w_busy;

  // Table writes are only honoured while idle so a running pass never sees
  // its descriptors change underneath it.
  layer_desc_regfile #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W),
    .DESC_W     (DESC_W)
  ) u_regfile (
    .clk     (clk),
    .i_we    (cfg_we && (r_state == ST_IDLE)),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data),
    .i_raddr (r_idx),
    .o_rdata (w_rd_data)
  );

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_bad       = desc_is_bad(r_desc);
  // Only the engine that was fired may end the layer.
  assign w_end_match = (r_desc.ltype == TYPE_DEPTH) ? dw_end : point_end;
  // No wrap past the last table slot.
  assign w_at_end    = r_desc.last || (r_idx == IDX_W'(NUM_LAYERS - 1));
  assign w_busy      = (r_state != ST_IDLE) && (r_state != ST_FIN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_CHECK;
      ST_CHECK: begin
        if (w_bad) begin
          w_next = ST_FIN;
        end else if (r_desc.ltype == TYPE_SKIP) begin
          w_next = ST_NEXT;
        end else begin
          w_next = ST_FIRE;
        end
      end
      ST_FIRE:  w_next = ST_WAIT;
      ST_WAIT:  if (w_end_match) w_next = ST_NEXT;
      ST_NEXT:  w_next = w_at_end ? ST_FIN : ST_LOAD;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Descriptor holding register, layer index and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_desc <= '0;
      r_idx  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ST_LOAD) begin
        r_desc <= unpack_desc(w_rd_data);
      end
      if (w_accept) begin
        r_idx <= '0;
      end else if ((r_state == ST_NEXT) && !w_at_end) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_accept) begin
        r_err <= 1'b0;
      end else if ((r_state == ST_CHECK) && w_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign point_en           = (r_state == ST_FIRE) && (r_desc.ltype == TYPE_POINT);
  assign dw_en              = (r_state == ST_FIRE) && (r_desc.ltype == TYPE_DEPTH);
  assign w_start_address    = r_desc.w_start;
  assign filter_channel_max = r_desc.ch_max;
  assign filter_number_max  = r_desc.fn_max;
  assign window_size_max    = r_desc.win_max;
  assign act_en             = r_desc.act_en;
  assign layer_idx          = r_idx;
  assign busy               = w_busy;
  assign done               = (r_state == ST_FIN);
  assign err                = r_err;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_layer_last;
  logic [31:0] r_wait_cnt;

  // Saturating pass-cycle counter and per-layer WAIT-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cycles     <= '0;
      r_perf_layer_last <= '0;
      r_wait_cnt        <= '0;
    end else begin
      if (w_accept) begin
        r_perf_cycles <= '0;
      end else if (w_busy && (r_perf_cycles != '1)) begin
        r_perf_cycles <= r_perf_cycles + 32'd1;
      end
      if (r_state == ST_FIRE) begin
        r_wait_cnt <= '0;
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != '1)) begin
        r_wait_cnt <= r_wait_cnt + 32'd1;
      end
      // The end cycle itself is a WAIT cycle, hence the +1.
      if ((r_state == ST_WAIT) && w_end_match) begin
        r_perf_layer_last <= (r_wait_cnt == '1) ? '1 : r_wait_cnt + 32'd1;
      end
    end
  end

  assign perf_cycles     = r_perf_cycles;
  assign perf_layer_last = r_perf_layer_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_sequencer
// Desc     : Self-checking bench for layer_sequencer. A timeline model
//            derives, from the descriptor table and engine latencies, the
//            cycle of every enable, the done cycle, final index and error.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;
  localparam int NL = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [37:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        point_end = 1'b0;
  logic        dw_end = 1'b0;
  logic        point_en, dw_en, act_en, busy, done, err;
  logic [9:0]  w_start_address;
  logic [3:0]  filter_channel_max;
  logic [5:0]  filter_number_max;
  logic [13:0] window_size_max;
  logic [3:0]  layer_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [37:0] tbl [NL];
  int          lat [NL];

  layer_sequencer #(.NUM_LAYERS(16), .IDX_W(4), .DESC_W(38)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .point_end(point_end),
    .dw_end(dw_end), .point_en(point_en), .dw_en(dw_en),
    .w_start_address(w_start_address),
    .filter_channel_max(filter_channel_max),
    .filter_number_max(filter_number_max),
    .window_size_max(window_size_max), .act_en(act_en),
    .layer_idx(layer_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [37:0] mk(input bit last, input bit [1:0] t,
      input bit a, input bit [9:0] w, input bit [3:0] ch, input bit [5:0] fn,
      input bit [13:0] win);
    return {last, t, a, w, ch, fn, win};
  endfunction

  task automatic write_slot(input int a, input logic [37:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a[3:0]; cfg_data = d; tbl[a] = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One network pass: start, react as the engines, compare every cycle
  // against the model timeline.
  task automatic run_pass(input bit inj_wrong, input bit inj_wr);
    int T, L, i, nx, done_c, fin_idx, fire_k, n;
    bit e_err, going, e_pe, e_de;
    int fc[$], fe[$], fi[$];
    int pt_end, dw_e, pt_idx, dw_idx;
    logic [37:0] d;
    logic [1:0]  typ;

    @(negedge clk);
    T = cyc; start = 1'b1;

    // Model: LOAD at L, CHECK L+1, enable L+2, end at enable+lat,
    // NEXT one cycle later, next LOAD after that, FIN after the final NEXT.
    L = T + 1; i = 0; e_err = 0; going = 1; done_c = 0;
    while (going) begin
      d = tbl[i]; typ = d[36:35];
      if (typ == 2'b11 || (typ != 2'b10 &&
          (d[23:20] == 0 || d[19:14] == 0 || d[13:0] == 0))) begin
        e_err = 1; done_c = L + 2; going = 0;
      end else begin
        if (typ == 2'b10) begin
          nx = L + 2;
        end else begin
          fc.push_back(L + 2); fe.push_back(int'(typ)); fi.push_back(i);
          nx = L + 2 + lat[i] + 1;
        end
        if (d[37] || i == NL - 1) begin
          done_c = nx + 1; going = 0;
        end else begin
          i++; L = nx + 1;
        end
      end
    end
    fin_idx = i;

    pt_end = -1; dw_e = -1; pt_idx = 0; dw_idx = 0;
    for (int c = T + 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      start = 1'b0; point_end = 1'b0; dw_end = 1'b0; cfg_we = 1'b0;
      fire_k = -1;
      for (int k = 0; k < fc.size(); k++) if (fc[k] == c) fire_k = k;
      e_pe = (fire_k >= 0) && (fe[fire_k] == 0);
      e_de = (fire_k >= 0) && (fe[fire_k] == 1);
      check("point_en", point_en, e_pe);
      check("dw_en", dw_en, e_de);
      check("busy", busy, (c < done_c));
      check("done", done, (c == done_c));
      check("err", err, (c >= done_c) ? e_err : 1'b0);
      if (fire_k >= 0) begin
        d = tbl[fi[fire_k]];
        check("fire_idx", layer_idx, fi[fire_k]);
        check("fire_wstart", w_start_address, d[33:24]);
        check("fire_ch", filter_channel_max, d[23:20]);
        check("fire_fn", filter_number_max, d[19:14]);
        check("fire_win", window_size_max, d[13:0]);
        check("fire_act", act_en, d[34]);
      end
      if (c >= done_c) check("final_idx", layer_idx, fin_idx);
      // engine behaviour, reacting to the DUT's own enables
      if (point_en) begin pt_end = c + lat[layer_idx]; pt_idx = int'(layer_idx); end
      if (dw_en)    begin dw_e   = c + lat[layer_idx]; dw_idx = int'(layer_idx); end
      if (inj_wrong && pt_end > c && $urandom_range(3) == 0) dw_end = 1'b1;
      if (inj_wrong && dw_e > c && $urandom_range(3) == 0) point_end = 1'b1;
      if (c == pt_end) begin
        point_end = 1'b1; d = tbl[pt_idx];
        check("wait_cfg_pt", {w_start_address, window_size_max}, {d[33:24], d[13:0]});
      end
      if (c == dw_e) begin
        dw_end = 1'b1; d = tbl[dw_idx];
        check("wait_cfg_dw", {w_start_address, window_size_max}, {d[33:24], d[13:0]});
      end
      if (inj_wr && busy && $urandom_range(2) == 0) begin
        cfg_we = 1'b1; cfg_addr = 4'($urandom_range(15));
        cfg_data = {1'b0, 2'b11, 35'($urandom)};
      end
    end

    // bounded drain in case the DUT lags the model
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      point_end = (cyc == pt_end) || (n % 7 == 0);
      dw_end = (cyc == dw_e) || (n % 7 == 0);
      cfg_we = 1'b0; n++;
    end
    @(negedge clk);
    point_end = 1'b0; dw_end = 1'b0; cfg_we = 1'b0;
    check("pass_idle", busy, 1'b0);
    if (busy) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0;
    end
  endtask

  initial begin : main
    bit found;
    int pend;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_point_en", point_en, 1'b0);
    check("rst_dw_en", dw_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_idx", layer_idx, 4'd0);
    check("rst_cfg", {w_start_address, filter_channel_max, filter_number_max,
                      window_size_max, act_en}, 35'd0);
    rst = 1'b0;

    // ---- two-layer pass ----
    write_slot(0, mk(0, 2'b00, 1, 10'h040, 4'd6, 6'd36, 14'd784));
    write_slot(1, mk(1, 2'b01, 0, 10'h155, 4'd3, 6'd8, 14'd100));
    lat[0] = 50; lat[1] = 30;
    run_pass(0, 0);

    // ---- skip layer ----
    write_slot(0, mk(0, 2'b10, 0, 10'h3ff, 4'd0, 6'd0, 14'd0));
    write_slot(1, mk(1, 2'b00, 1, 10'h222, 4'd2, 6'd5, 14'd17));
    lat[1] = 4;
    run_pass(0, 0);

    // ---- illegal descriptor, then err clears on next start ----
    write_slot(0, mk(1, 2'b00, 1, 10'h001, 4'd2, 6'd2, 14'd0));
    run_pass(0, 0);
    check("err_sticky_idle", err, 1'b1);
    write_slot(0, mk(1, 2'b01, 1, 10'h011, 4'd1, 6'd1, 14'd1));
    lat[0] = 2;
    run_pass(0, 0);

    // ---- wrong-engine end pulses during WAIT ----
    write_slot(0, mk(0, 2'b00, 0, 10'h0aa, 4'd4, 6'd9, 14'd33));
    write_slot(1, mk(1, 2'b01, 1, 10'h0bb, 4'd5, 6'd7, 14'd21));
    lat[0] = 25; lat[1] = 25;
    run_pass(1, 0);

    // ---- table bound and write lock: 16 point layers, none last ----
    for (int k = 0; k < NL; k++) begin
      write_slot(k, mk(0, 2'b00, k[0], 10'(k * 7 + 1), 4'(k % 15 + 1),
                       6'(k + 2), 14'(k * 3 + 5)));
      lat[k] = 2 + (k % 3);
    end
    run_pass(0, 1);
    run_pass(0, 0);

    // ---- reset mid-WAIT ----
    write_slot(0, mk(0, 2'b00, 1, 10'h010, 4'd1, 6'd1, 14'd1));
    write_slot(1, mk(1, 2'b00, 1, 10'h020, 4'd2, 6'd2, 14'd2));
    lat[0] = 3; lat[1] = 6;
    @(negedge clk); start = 1'b1;
    found = 0; pend = -1;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      start = 1'b0; point_end = 1'b0;
      if (point_en && layer_idx == 4'd0) pend = cyc + 3;
      if (cyc == pend) point_end = 1'b1;
      if (point_en && layer_idx == 4'd1) found = 1;
    end
    check("rstw_reached_layer1", found, 1'b1);
    repeat (3) @(negedge clk);
    check("rstw_busy_before", busy, 1'b1);
    @(posedge clk); #2 rst = 1'b1; #1;
    check("rstw_busy", busy, 1'b0);
    check("rstw_point_en", point_en, 1'b0);
    check("rstw_done", done, 1'b0);
    check("rstw_err", err, 1'b0);
    check("rstw_idx", layer_idx, 4'd0);
    @(negedge clk); rst = 1'b0;
    run_pass(0, 0);

    // ---- randomized tables ----
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < NL; k++) begin
        int sel;
        logic [37:0] d;
        sel = $urandom_range(19);
        d = mk(($urandom_range(4) == 0), 2'($urandom_range(1)), 1'($urandom),
               10'($urandom), 4'($urandom_range(15, 1)), 6'($urandom_range(63, 1)),
               14'($urandom_range(16383, 1)));
        if (sel == 0) d[36:35] = 2'b11;
        else if (sel == 1) d[13:0] = '0;
        else if (sel == 2) d[19:14] = '0;
        else if (sel < 6) d[36:35] = 2'b10;
        write_slot(k, d);
        lat[k] = $urandom_range(12, 1);
      end
      run_pass(r[0], (r % 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Top-level layer scheduler for the MobileNetV3 accelerator.
- Holds a programmable table of layer descriptors and drives the pointwise and depthwise engine controllers: presents each layer's configuration, fires the engine's one-cycle enable, waits for its end pulse, then advances.
- Signals completion of the whole network pass to the host/top FSM.

Parameters:
- NUM_LAYERS, 16, descriptor table depth.
- IDX_W, 4, width of layer index (clog2 NUM_LAYERS).
- DESC_W, 38, descriptor width (fixed by field layout below).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- cfg_we  in  1  descriptor write strobe
- cfg_addr  in  IDX_W  descriptor slot
- cfg_data  in  DESC_W  descriptor: [37] last, [36:35] type (00 point, 01 depth, 10 skip, 11 illegal), [34] act_en, [33:24] w_start, [23:20] ch_max, [19:14] fn_max, [13:0] win_max
- start  in  1  single-cycle start of a network pass
- point_end  in  1  end pulse from pointwise controller
- dw_end  in  1  end pulse from depthwise controller
- point_en  out  1  one-cycle enable to pointwise controller
- dw_en  out  1  one-cycle enable to depthwise controller
- w_start_address  out  10  registered config
- filter_channel_max  out  4  registered config
- filter_number_max  out  6  registered config
- window_size_max  out  14  registered config
- act_en  out  1  activation enable for current layer
- layer_idx  out  IDX_W  index of current layer
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of pass
- err  out  1  sticky error flag; cleared by next accepted start

Behaviour:
- Reset: all outputs 0; FSM to IDLE; table contents undefined (must be written before the first pass).
- States: IDLE, LOAD, CHECK, FIRE, WAIT, NEXT, FIN.
- IDLE:
  - start -> LOAD with layer_idx=0, err cleared, busy=1 from the next cycle.
  - cfg_we writes the table only in IDLE; writes in any other state are dropped.
- LOAD: read descriptor[layer_idx] into holding regs; drive config outputs from them. Outputs stay stable from LOAD until leaving WAIT.
- CHECK:
  - type=11, or type in {00,01} with ch_max==0, fn_max==0 or win_max==0 -> set err, go to FIN (abort).
  - type=10 -> NEXT (no enable fired).
  - Otherwise -> FIRE.
- FIRE: assert point_en (type 00) or dw_en (type 01) for exactly one cycle -> WAIT. Latency from start to first enable is exactly 3 cycles (start at T -> LOAD T+1, CHECK T+2, enable T+3).
- WAIT:
  - Only the end pulse of the engine fired counts; the other engine's end pulse is ignored.
  - A matching end pulse arriving in the same cycle as the FIRE enable is impossible by engine contract and is not checked.
  - On matching end -> NEXT.
- NEXT:
  - If last=1 or layer_idx==NUM_LAYERS-1 -> FIN (no wrap).
  - Else layer_idx+1 -> LOAD.
- FIN: done=1 for one cycle, busy=0 on that same cycle -> IDLE. layer_idx holds its final value until the next start.
- start while busy is ignored.
- Asynchronous rst mid-pass: immediate return to IDLE, enables and busy forced to 0; the engines are reset by the same rst.
- Arithmetic: layer_idx is an unsigned IDX_W counter; no other arithmetic.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined:
  - Extra output perf_cycles (32 bits), cleared on an accepted start.
  - Increments every cycle while busy, saturates at all-ones, holds after done.
  - Extra output perf_layer_last (32 bits) holds the WAIT-state cycle count of the most recently completed layer.
- Undefined: neither port nor counters exist; behaviour otherwise identical.

Decomposition:
- Package seq_pkg: descriptor bit-field offsets/widths, type encodings (TYPE_POINT, TYPE_DEPTH, TYPE_SKIP, TYPE_ILLEGAL), FSM state encoding, DESC_W constant.
- One sub-module, layer_desc_regfile: NUM_LAYERS x DESC_W register array with a synchronous write port and a combinational read port, addressed by cfg_addr/layer_idx.

Test Plan:
- Two-layer pass:
  - Stimulus: layer0 point (w_start=0x040, ch=6, fn=36, win=784), layer1 depth last=1; start at T; point_end 50 cycles after point_en; dw_end 30 cycles after dw_en.
  - Required: point_en at T+3 with config stable; dw_en 4 cycles after point_end; done one cycle after dw_end+1; err=0.
- Skip layer:
  - Stimulus: layer0 type=10, layer1 point last=1.
  - Required: no dw_en/point_en for layer0; point_en fires with layer_idx=1.
- Illegal descriptor:
  - Stimulus: layer0 point with win_max=0.
  - Required: no enable fired, err=1, done pulse at T+3, err clears on next start.
- Wrong-engine end:
  - Stimulus: layer0 point; dw_end pulses during WAIT.
  - Required: FSM stays in WAIT, no advance until point_end.
- Table bound and write lock:
  - Stimulus: all 16 layers point, none last; issue cfg_we during the pass.
  - Required: done after layer_idx=15 with no wrap; table unchanged.
- Reset mid-WAIT:
  - Stimulus: rst asserted mid-WAIT.
  - Required: busy, point_en, done, err and layer_idx all 0 in the same cycle; a new start runs normally from layer 0.
